space_invaders_top: RTL and testbench



---
 rtl/space_invaders_top.sv | 240 ++++++++++++++++++++++++
 tb/tb_space_invaders_top.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/space_invaders_top.sv
// Space Invaders demo: 640x480@60 VGA timing, PS/2 mouse receiver and single-screen game.
// Game state advances only on the frame tick; pixels are registered one clk behind the counters.
module space_invaders_top (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] btn1,
   input  logic [1:0] btn2,
   inout  wire        ps2d,
   inout  wire        ps2c,
   output logic [7:0] led,
   output logic       hsync,
   output logic       vsync,
   output logic       M,
   output logic [7:0] rgb
);
   assign ps2d = 1'bz;
   assign ps2c = 1'bz;

   logic [9:0] x, y;
   logic       ftick;

   always_ff @(posedge clk) begin
      if (reset) begin
         M <= 1'b0;
         x <= '0;
         y <= '0;
      end else begin
         M <= ~M;
         if (M) begin
            if (x == 10'd799) begin
               x <= '0;
               y <= (y == 10'd524) ? '0 : y + 10'd1;
            end else begin
               x <= x + 10'd1;
            end
         end
      end
   end

   assign ftick = M && (x == '0) && (y == 10'd480);

   logic [1:0]  c_sync, d_sync;
   logic        c_prev, fall, byte_done, frame_ok, byte_ok, byte_bad;
   logic [16:0] wdog;
   logic [3:0]  bitcnt;
   logic [9:0]  sr;
   logic [10:0] frame;

   assign fall      = c_prev & ~c_sync[1];
   assign frame     = {d_sync[1], sr};
   assign byte_done = fall && (bitcnt == 4'd10);
   assign frame_ok  = ~frame[0] & frame[10] & (^frame[9:1]);
   assign byte_ok   = byte_done & frame_ok;
   assign byte_bad  = byte_done & ~frame_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         c_sync <= '1;
         d_sync <= '1;
         c_prev <= 1'b1;
         wdog   <= '0;
         bitcnt <= '0;
         sr     <= '0;
      end else begin
         c_sync <= {c_sync[0], ps2c};
         d_sync <= {d_sync[0], ps2d};
         c_prev <= c_sync[1];
         if (c_prev != c_sync[1])
            wdog <= '0;
         else if (wdog != '1)
            wdog <= wdog + 17'd1;
         if (fall) begin
            sr     <= frame[10:1];
            bitcnt <= (bitcnt == 4'd10) ? '0 : bitcnt + 4'd1;
         end else if (wdog == '1) begin
            bitcnt <= '0;
         end
      end
   end

   typedef enum logic [1:0] {PKT_B0, PKT_B1, PKT_B2} pkt_t;
   pkt_t pst, pnxt;
   logic pkt_done, b0_sign, b0_left, mleft;
   logic [7:0] b1;

   always_comb begin
      pnxt     = pst;
      pkt_done = 1'b0;
      if (byte_bad) begin
         pnxt = PKT_B0;
      end else if (byte_ok) begin
         case (pst)
            PKT_B0:  if (frame[4]) pnxt = PKT_B1;
            PKT_B1:  pnxt = PKT_B2;
            PKT_B2:  begin pnxt = PKT_B0; pkt_done = 1'b1; end
            default: pnxt = PKT_B0;
         endcase
      end
   end

   logic signed [8:0] dx;
   logic signed [9:0] pend, pend_sum;
   assign dx = {b0_sign, b1};

   always_comb begin
      pend_sum = (ftick ? 10'sd0 : pend) + {dx[8], dx};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pst     <= PKT_B0;
         b0_sign <= 1'b0;
         b0_left <= 1'b0;
         b1      <= '0;
         pend    <= '0;
         mleft   <= 1'b0;
      end else begin
         pst <= pnxt;
         if (byte_ok && pst == PKT_B0) begin
            b0_sign <= frame[5];
            b0_left <= frame[1];
         end
         if (byte_ok && pst == PKT_B1) b1 <= frame[8:1];
         // a packet landing on the frame tick starts the next frame's accumulator
         if (pkt_done) begin
            mleft <= b0_left;
            if (pend_sum > 10'sd255)       pend <= 10'sd255;
            else if (pend_sum < -10'sd255) pend <= -10'sd255;
            else                           pend <= pend_sum;
         end else if (ftick) begin
            pend <= '0;
         end
      end
   end

   logic [9:0] ship_x, bx, by, ax, ay, ship_new;
   logic       bact, dir_r, over, hit;
   logic [7:0] alive, score;
   logic [2:0] hit_idx;
   logic [10:0] ai;
   logic signed [11:0] snext, bstep;

   assign over = (ay >= 10'd432);
   assign led  = score;

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      ai      = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         ai = {1'b0, ax} + 11'(i * 64);
         if (!hit && bact && alive[i] && ({1'b0, bx} < ai + 11'd32) && ({1'b0, bx} + 11'd2 > ai) &&
             (by < ay + 10'd16) && (by + 10'd8 > ay)) begin
            hit     = 1'b1;
            hit_idx = 3'(i);
         end
      end
   end

   always_comb begin
      bstep = 12'sd0;
      if (btn1 == 2'b10)      bstep = 12'sd4;
      else if (btn1 == 2'b01) bstep = -12'sd4;
      snext = $signed({2'b00, ship_x}) + $signed({{2{pend[9]}}, pend}) + bstep;
      if (snext < 12'sd0)        ship_new = '0;
      else if (snext > 12'sd608) ship_new = 10'd608;
      else                       ship_new = snext[9:0];
   end

   always_ff @(posedge clk) begin
      if (reset || btn2[1]) begin
         ship_x <= 10'd304;
         bx     <= '0;
         by     <= '0;
         bact   <= 1'b0;
         ax     <= '0;
         ay     <= 10'd64;
         dir_r  <= 1'b1;
         alive  <= '1;
         score  <= '0;
      end else if (ftick && !over) begin
         ship_x <= ship_new;
         if (hit) begin
            bact <= 1'b0;
         end else if (bact) begin
            if (by < 10'd8) bact <= 1'b0;
            else            by   <= by - 10'd8;
         end else if (btn2[0] || mleft) begin
            bx   <= ship_x + 10'd15;
            by   <= 10'd440;
            bact <= 1'b1;
         end
         if (alive == '0) begin
            alive <= '1;
            ax    <= '0;
            ay    <= 10'd64;
            dir_r <= 1'b1;
         end else if (hit) begin
            alive[hit_idx] <= 1'b0;
            score          <= score + 8'd1;
         end else if ((dir_r && ax == 10'd160) || (!dir_r && ax == '0)) begin
            dir_r <= ~dir_r;
            ay    <= ay + 10'd16;
         end else begin
            ax <= dir_r ? ax + 10'd1 : ax - 10'd1;
         end
      end
   end

   logic [4:0] rel_hi;
   logic       bullet_px, ship_px, alien_px, disp;
   logic [7:0] colour;

   // rel_hi = (x-ax)/32: bit0 selects the gap half of each 64-px slot, bits 3:1 the alien
   assign rel_hi = 5'((x - ax) >> 5);

   always_comb begin
      disp      = (x < 10'd640) && (y < 10'd480);
      bullet_px = bact && (x >= bx) && (x < bx + 10'd2) && (y >= by) && (y < by + 10'd8);
      ship_px   = (x >= ship_x) && (x < ship_x + 10'd32) && (y >= 10'd448) && (y < 10'd464);
      alien_px  = (x >= ax) && (y >= ay) && (y < ay + 10'd16) && !rel_hi[4] && !rel_hi[0] &&
                  alive[rel_hi[3:1]];
      if (bullet_px)     colour = 8'hFC;
      else if (ship_px)  colour = 8'h1C;
      else if (alien_px) colour = 8'hFF;
      else               colour = over ? 8'hE0 : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         rgb   <= '0;
      end else begin
         hsync <= !((x >= 10'd656) && (x <= 10'd751));
         vsync <= !((y == 10'd490) || (y == 10'd491));
         rgb   <= disp ? colour : 8'h00;
      end
   end
endmodule

// File: tb/tb_space_invaders_top.sv
// Directed bench for space_invaders_top; after the sync timing checks the raster counters are
// pinned by force so that frame ticks and single pixels can be reached in a few clocks.
module tb_space_invaders_top;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] btn1 = '0;
   logic [1:0] btn2 = '0;
   logic       ps2c_drv = 1'b1;
   logic       ps2d_drv = 1'b1;
   wire        ps2c, ps2d;
   logic [7:0] led, rgb;
   logic       hsync, vsync, M;
   logic [9:0] fx, fy;
   int         passed = 0;
   int         total = 0;
   int         t, t_fall1, t_rise, t_fall2;

   assign ps2c = ps2c_drv;
   assign ps2d = ps2d_drv;

   space_invaders_top dut (
      .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2), .ps2d(ps2d), .ps2c(ps2c),
      .led(led), .hsync(hsync), .vsync(vsync), .M(M), .rgb(rgb)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic frames(input int n);
      fx = 10'd0;
      repeat (2 * n) @(negedge clk);
      fx = 10'd1;
   endtask

   task automatic peek(input string tag, input logic [9:0] px, input logic [9:0] py,
                       input logic [7:0] exp);
      fx = px;
      fy = py;
      repeat (2) @(negedge clk);
      chk(tag, rgb, exp);
      fx = 10'd1;
      fy = 10'd480;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input bit bad);
      logic [10:0] f;
      f = {1'b1, (~^d) ^ bad, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         ps2d_drv = f[i];
         repeat (10) @(negedge clk);
         ps2c_drv = 1'b0;
         repeat (10) @(negedge clk);
         ps2c_drv = 1'b1;
         repeat (10) @(negedge clk);
      end
      ps2d_drv = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input bit bad_b);
      send_byte(a, 1'b0);
      send_byte(b, bad_b);
      send_byte(8'h00, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_M", M, 0);
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_led", led, 0);
      chk("rst_rgb", rgb, 0);
      chk("rst_ship_x", dut.ship_x, 304);
      chk("rst_alive", dut.alive, 8'hFF);
      chk("rst_ay", dut.ay, 64);
      reset = 1'b0;

      t = 0;
      do begin @(negedge clk); t++; end while (hsync && t < 4000);
      t_fall1 = t;
      do begin @(negedge clk); t++; end while (!hsync && t < 8000);
      t_rise = t;
      do begin @(negedge clk); t++; end while (hsync && t < 12000);
      t_fall2 = t;
      chk("hsync_first_low", t_fall1, 1313);
      chk("hsync_low_width", t_rise - t_fall1, 192);
      chk("hsync_period", t_fall2 - t_fall1, 1600);

      fx = 10'd1;
      fy = 10'd480;
      force dut.x = fx;
      force dut.y = fy;
      repeat (2) @(negedge clk);
      fy = 10'd490;
      repeat (2) @(negedge clk);
      chk("vsync_low", vsync, 0);
      fy = 10'd480;
      fx = 10'd700;
      repeat (2) @(negedge clk);
      chk("hsync_low", hsync, 0);
      fx = 10'd1;
      repeat (2) @(negedge clk);
      chk("hsync_high", hsync, 1);

      btn1 = 2'b10;
      frames(10);
      chk("ship_right10", dut.ship_x, 344);
      btn1 = 2'b11;
      frames(3);
      chk("ship_both", dut.ship_x, 344);
      btn1 = 2'b01;
      frames(100);
      chk("ship_clamp0", dut.ship_x, 0);
      btn1 = 2'b00;
      peek("rgb_ship", 10'd5, 10'd450, 8'h1C);

      do_reset();
      send_pkt(8'h08, 8'h10, 1'b0);
      chk("mouse_midframe", dut.ship_x, 304);
      frames(1);
      chk("mouse_plus16", dut.ship_x, 320);
      frames(1);
      chk("mouse_consumed", dut.ship_x, 320);
      send_pkt(8'h18, 8'hF0, 1'b0);
      frames(1);
      chk("mouse_minus16", dut.ship_x, 304);
      send_pkt(8'h08, 8'h10, 1'b1);
      frames(1);
      chk("mouse_bad_parity", dut.ship_x, 304);
      send_pkt(8'h08, 8'h10, 1'b0);
      frames(1);
      chk("mouse_resync", dut.ship_x, 320);
      send_pkt(8'h08, 8'hFF, 1'b0);
      send_pkt(8'h08, 8'hFF, 1'b0);
      frames(1);
      chk("mouse_saturate", dut.ship_x, 575);
      send_pkt(8'h08, 8'hFF, 1'b0);
      frames(1);
      chk("ship_clamp608", dut.ship_x, 608);

      do_reset();
      send_pkt(8'h18, 8'h01, 1'b0);
      frames(1);
      chk("ship_minus255", dut.ship_x, 49);
      chk("alien_ax1", dut.ax, 1);
      btn2 = 2'b01;
      frames(1);
      chk("fire_active", dut.bact, 1);
      chk("fire_bx", dut.bx, 64);
      chk("fire_by", dut.by, 440);
      frames(1);
      chk("refire_by", dut.by, 432);
      chk("refire_bx", dut.bx, 64);
      btn2 = 2'b00;
      frames(45);
      chk("bullet_by72", dut.by, 72);
      chk("pre_hit_alive", dut.alive, 8'hFF);
      chk("pre_hit_led", led, 0);
      chk("pre_hit_ax", dut.ax, 48);
      peek("rgb_bullet", 10'd64, 10'd75, 8'hFC);
      peek("rgb_alien", 10'd50, 10'd70, 8'hFF);
      peek("rgb_gap", 10'd100, 10'd70, 8'h00);
      frames(1);
      chk("hit_alive", dut.alive, 8'hFE);
      chk("hit_led", led, 1);
      chk("hit_bullet_off", dut.bact, 0);
      chk("hit_no_move", dut.ax, 48);
      peek("rgb_dead_alien", 10'd50, 10'd70, 8'h00);

      frames(3654);
      chk("march_ay416", dut.ay, 416);
      peek("rgb_bg_play", 10'd300, 10'd200, 8'h00);
      frames(1);
      chk("gameover_ay", dut.ay, 432);
      btn1 = 2'b10;
      frames(5);
      btn1 = 2'b00;
      chk("frozen_ax", dut.ax, 160);
      chk("frozen_ay", dut.ay, 432);
      chk("frozen_ship", dut.ship_x, 49);
      chk("gameover_led", led, 1);
      peek("rgb_bg_over", 10'd300, 10'd200, 8'hE0);

      btn2 = 2'b10;
      repeat (2) @(negedge clk);
      btn2 = 2'b00;
      chk("restart_ay", dut.ay, 64);
      chk("restart_led", led, 0);
      chk("restart_alive", dut.alive, 8'hFF);
      chk("restart_ship", dut.ship_x, 304);
      peek("rgb_bg_restart", 10'd300, 10'd200, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
